// File: rtl/audio_sample_scheduler_pkg.sv
// Shared audio constants, FSM state type and phase-increment helper.
package audio_sample_scheduler_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, FULL} sched_state_e;

    localparam int     AUDIO_BITS_DEF = 12;
    localparam int     ACC_W_DEF      = 24;
    localparam longint SYS_CLK_HZ     = 50_000_000;
    localparam longint SAMPLE_HZ      = 44_100;

    // round(sample_hz * 2^acc_w / clk_hz)
    function automatic int phase_inc_for(input int acc_w, input longint sample_hz,
                                         input longint clk_hz);
        longint num;
        num = sample_hz * (longint'(1) << acc_w);
        return int'((num + clk_hz / 2) / clk_hz);
    endfunction

    localparam int PHASE_INC_DEF = phase_inc_for(ACC_W_DEF, SAMPLE_HZ, SYS_CLK_HZ);

endpackage

// File: rtl/audio_sample_scheduler_phase_tick.sv
// audio_phase_tick: fractional phase accumulator whose carry-out becomes a
// registered one-clk tick; clearing enable zeroes the phase.
module audio_phase_tick
    import audio_sample_scheduler_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int PHASE_INC = PHASE_INC_DEF
) (
    input  logic clk,
    input  logic aclr,
    input  logic enable,
    output logic tick
);

    localparam logic [ACC_W:0] INC = (ACC_W+1)'(PHASE_INC);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + INC;

    // A carry landing while enable is low is lost because acc clears.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            acc  <= sum[ACC_W-1:0];
            tick <= sum[ACC_W];
        end else begin
            acc  <= '0;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Stereo PCM sample scheduler: prefetches one sample per tick and presents it to
// the DSM. Optional macro AUDIO_SCHED_UNDERRUN_COUNT_EN adds underrun_count.
module audio_sample_scheduler
    import audio_sample_scheduler_pkg::*;
#(
    parameter int AUDIO_BITS       = AUDIO_BITS_DEF,
    parameter int ACC_W            = ACC_W_DEF,
    parameter int PHASE_INC        = PHASE_INC_DEF,
    parameter bit MUTE_ON_UNDERRUN = 1'b0
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  enable,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [AUDIO_BITS-1:0] src_left,
    input  logic [AUDIO_BITS-1:0] src_right,
    output logic [AUDIO_BITS-1:0] left_pcm,
    output logic [AUDIO_BITS-1:0] right_pcm,
    output logic                  sample_tick,
    output logic                  underrun
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]           underrun_count
`endif
);

    localparam logic [AUDIO_BITS-1:0] MUTE_VALUE = {1'b1, {(AUDIO_BITS-1){1'b0}}};

    sched_state_e          state, state_n;
    logic [AUDIO_BITS-1:0] pf_left, pf_right, pf_left_n, pf_right_n;
    logic [AUDIO_BITS-1:0] left_n, right_n;
    logic                  underrun_n;
    logic                  xfer;

    audio_phase_tick #(
        .ACC_W    (ACC_W),
        .PHASE_INC(PHASE_INC)
    ) u_phase_tick (
        .clk   (clk),
        .aclr  (aclr),
        .enable(enable),
        .tick  (sample_tick)
    );

    assign src_ready = (state == FETCH);
    assign xfer      = src_valid & src_ready;

    always_comb begin
        state_n    = state;
        pf_left_n  = pf_left;
        pf_right_n = pf_right;
        left_n     = left_pcm;
        right_n    = right_pcm;
        underrun_n = 1'b0;
        // Dropping enable wins over everything: outputs hold, prefetch is abandoned.
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = FETCH;
                FETCH: begin
                    if (sample_tick && xfer) begin
                        left_n  = src_left;
                        right_n = src_right;
                    end else if (sample_tick) begin
                        underrun_n = 1'b1;
                        if (MUTE_ON_UNDERRUN) begin
                            left_n  = MUTE_VALUE;
                            right_n = MUTE_VALUE;
                        end
                    end else if (xfer) begin
                        pf_left_n  = src_left;
                        pf_right_n = src_right;
                        state_n    = FULL;
                    end
                end
                FULL: begin
                    if (sample_tick) begin
                        left_n  = pf_left;
                        right_n = pf_right;
                        state_n = FETCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            pf_left   <= MUTE_VALUE;
            pf_right  <= MUTE_VALUE;
            left_pcm  <= MUTE_VALUE;
            right_pcm <= MUTE_VALUE;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            pf_left   <= pf_left_n;
            pf_right  <= pf_right_n;
            left_pcm  <= left_n;
            right_pcm <= right_n;
            underrun  <= underrun_n;
        end
    end

`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            underrun_count <= '0;
        else if (!enable)
            underrun_count <= '0;
        else if (underrun_n && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: expected samples are queued as the
// source is driven and popped when the outputs update after a tick.
module tb_audio_sample_scheduler;
    import audio_sample_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        en_a = 1'b0, en_d = 1'b0, en_f = 1'b0;
    logic        src_valid = 1'b0;
    logic [11:0] src_left = '0, src_right = '0;

    logic        rdy_a, rdy_d, rdy_0, rdy_1;
    logic [11:0] l_a, r_a, l_d, r_d, l_0, r_0, l_1, r_1;
    logic        tk_a, tk_d, tk_0, tk_1;
    logic        ur_a, ur_d, ur_0, ur_1;
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
    logic [15:0] uc_a, uc_d, uc_0, uc_1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] q0[$];
    logic [23:0] q1[$];

    always #10 clk = ~clk;

    // Fast tick (every 4 clks)
    audio_sample_scheduler #(.PHASE_INC(4194304)) dut_a (
        .clk(clk), .aclr(aclr), .enable(en_a), .src_valid(src_valid), .src_ready(rdy_a),
        .src_left(src_left), .src_right(src_right), .left_pcm(l_a), .right_pcm(r_a),
        .sample_tick(tk_a), .underrun(ur_a)
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
        , .underrun_count(uc_a)
`endif
    );

    // All defaults (44.1 kHz from 50 MHz)
    audio_sample_scheduler dut_d (
        .clk(clk), .aclr(aclr), .enable(en_d), .src_valid(src_valid), .src_ready(rdy_d),
        .src_left(src_left), .src_right(src_right), .left_pcm(l_d), .right_pcm(r_d),
        .sample_tick(tk_d), .underrun(ur_d)
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
        , .underrun_count(uc_d)
`endif
    );

    // Tick every 32 clks, hold vs mute on underrun
    audio_sample_scheduler #(.PHASE_INC(524288), .MUTE_ON_UNDERRUN(1'b0)) dut_0 (
        .clk(clk), .aclr(aclr), .enable(en_f), .src_valid(src_valid), .src_ready(rdy_0),
        .src_left(src_left), .src_right(src_right), .left_pcm(l_0), .right_pcm(r_0),
        .sample_tick(tk_0), .underrun(ur_0)
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
        , .underrun_count(uc_0)
`endif
    );

    audio_sample_scheduler #(.PHASE_INC(524288), .MUTE_ON_UNDERRUN(1'b1)) dut_1 (
        .clk(clk), .aclr(aclr), .enable(en_f), .src_valid(src_valid), .src_ready(rdy_1),
        .src_left(src_left), .src_right(src_right), .left_pcm(l_1), .right_pcm(r_1),
        .sample_tick(tk_1), .underrun(ur_1)
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
        , .underrun_count(uc_1)
`endif
    );

    task automatic do_reset();
        en_a = 1'b0; en_d = 1'b0; en_f = 1'b0;
        src_valid = 1'b0; src_left = '0; src_right = '0;
        q0.delete(); q1.delete();
        @(negedge clk);
        aclr = 1'b1;
        repeat (2) @(negedge clk);
        aclr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({l_0, r_0, l_d, r_d} !== {4{12'h800}}) begin
            n_fail++;
            $display("FAIL reset_pcm: got %h %h %h %h want 800", l_0, r_0, l_d, r_d);
        end
        n_checks++;
        if ({rdy_0, rdy_1, rdy_a, rdy_d, tk_0, tk_a, tk_d, ur_0, ur_1, ur_d} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/tick/underrun got %b want 0",
                     {rdy_0, rdy_1, rdy_a, rdy_d, tk_0, tk_a, tk_d, ur_0, ur_1, ur_d});
        end
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
        n_checks++;
        if (uc_0 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", uc_0);
        end
`endif
    endtask

    // Tick every 4 clks; enable dropped across the cycle-16 carry suppresses it.
    task automatic test_tick_fast();
        logic e;
        do_reset();
        en_a = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            e = ((c <= 12) && (c % 4 == 0)) || (c == 24) || (c == 28);
            n_checks++;
            if (tk_a !== e) begin
                n_fail++;
                $display("FAIL tick_fast c=%0d: got %b want %b", c, tk_a, e);
            end
            en_a = !(c >= 15 && c <= 19);
        end
        en_a = 1'b0;
    endtask

    task automatic test_tick_default();
        int     ticks, last, gmin, gmax;
        longint want;
        ticks = 0; last = -1; gmin = 1 << 30; gmax = 0;
        do_reset();
        en_d = 1'b1;
        for (int c = 1; c <= 40000; c++) begin
            @(negedge clk);
            if (tk_d === 1'b1) begin
                if (last >= 0) begin
                    if (c - last < gmin) gmin = c - last;
                    if (c - last > gmax) gmax = c - last;
                end
                last = c;
                ticks++;
            end
        end
        en_d = 1'b0;
        want = (longint'(40000) * 14798) >> 24;
        n_checks++;
        if (longint'(ticks) != want) begin
            n_fail++;
            $display("FAIL tick_count: got %0d want %0d", ticks, want);
        end
        n_checks++;
        if (gmin < 1133 || gmax > 1134) begin
            n_fail++;
            $display("FAIL tick_spacing: got min %0d max %0d want 1133..1134", gmin, gmax);
        end
    endtask

    task automatic test_ramp();
        logic [11:0] ramp;
        logic [23:0] exp;
        logic        pend;
        int          outs, urs, cyc;
        ramp = '0; pend = 1'b0; outs = 0; urs = 0; cyc = 0;
        do_reset();
        en_f = 1'b1;
        while (outs < 6 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                exp = q0.pop_front();
                n_checks++;
                if ({l_0, r_0} !== exp) begin
                    n_fail++;
                    $display("FAIL ramp_out %0d: got %h %h want %h %h", outs, l_0, r_0,
                             exp[23:12], exp[11:0]);
                end
                outs++;
                pend = 1'b0;
            end
            if (ur_0 === 1'b1) urs++;
            src_valid = 1'b1;
            src_left  = ramp;
            src_right = ~ramp;
            if (rdy_0 === 1'b1) begin
                q0.push_back({ramp, ~ramp});
                ramp++;
            end
            if (tk_0 === 1'b1 && q0.size() != 0) pend = 1'b1;
        end
        src_valid = 1'b0;
        n_checks++;
        if (outs != 6) begin
            n_fail++;
            $display("FAIL ramp_timeout: got %0d outputs want 6", outs);
        end
        n_checks++;
        if (urs != 0) begin
            n_fail++;
            $display("FAIL ramp_underrun: got %0d pulses want 0", urs);
        end
        en_f = 1'b0;
    endtask

    task automatic test_underrun();
        logic [23:0] e0, e1;
        logic        pend, sent;
        int          ticks, u0, u1, cyc;
        pend = 1'b0; sent = 1'b0; ticks = 0; u0 = 0; u1 = 0; cyc = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({12'h2A5, 12'h15A});
            q1.push_back(i == 0 ? {12'h2A5, 12'h15A} : {12'h800, 12'h800});
        end
        en_f = 1'b1;
        while (!(ticks == 4 && !pend) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                n_checks++;
                if ({l_0, r_0} !== e0 || {l_1, r_1} !== e1) begin
                    n_fail++;
                    $display("FAIL underrun_out tick %0d: got %h%h/%h%h want %h/%h", ticks,
                             l_0, r_0, l_1, r_1, e0, e1);
                end
                pend = 1'b0;
            end
            if (ur_0 === 1'b1) u0++;
            if (ur_1 === 1'b1) u1++;
            src_valid = !sent;
            src_left  = 12'h2A5;
            src_right = 12'h15A;
            if (src_valid && rdy_0 === 1'b1) sent = 1'b1;
            if (tk_0 === 1'b1) begin
                ticks++;
                pend = 1'b1;
            end
        end
        src_valid = 1'b0;
        n_checks++;
        if (ticks != 4) begin
            n_fail++;
            $display("FAIL underrun_timeout: got %0d ticks want 4", ticks);
        end
        n_checks++;
        if (u0 != 3 || u1 != 3) begin
            n_fail++;
            $display("FAIL underrun_pulses: got %0d/%0d want 3/3", u0, u1);
        end
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
        n_checks++;
        if (uc_0 !== 16'd3) begin
            n_fail++;
            $display("FAIL underrun_count: got %0d want 3", uc_0);
        end
`endif
        en_f = 1'b0;
    endtask

    task automatic test_bypass();
        logic [23:0] exp;
        logic        hit;
        hit = 1'b0;
        do_reset();
        en_f = 1'b1;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (tk_0 === 1'b1 && rdy_0 === 1'b1) begin
                src_valid = 1'b1;
                src_left  = 12'h123;
                src_right = 12'h321;
                q0.push_back({12'h123, 12'h321});
                hit = 1'b1;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL bypass_timeout: got no tick in FETCH want one within 100 clks");
        end else begin
            @(negedge clk);
            src_valid = 1'b0;
            exp = q0.pop_front();
            if ({l_0, r_0} !== exp) begin
                n_fail++;
                $display("FAIL bypass_out: got %h %h want %h %h", l_0, r_0, exp[23:12], exp[11:0]);
            end
            n_checks++;
            if (ur_0 !== 1'b0 || rdy_0 !== 1'b1) begin
                n_fail++;
                $display("FAIL bypass_ctrl: got underrun %b ready %b want 0 1", ur_0, rdy_0);
            end
        end
        en_f = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic sent, seen;
        sent = 1'b0; seen = 1'b0;
        do_reset();
        en_f = 1'b1;
        for (int c = 0; c < 20 && !sent; c++) begin
            @(negedge clk);
            src_valid = 1'b1;
            src_left  = 12'h456;
            src_right = 12'h654;
            if (rdy_0 === 1'b1) sent = 1'b1;
        end
        @(negedge clk);
        src_valid = 1'b0;
        n_checks++;
        if (rdy_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_full: got ready %b want 0", rdy_0);
        end
        en_f = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdy_0 !== 1'b0 || l_0 !== 12'h800) begin
            n_fail++;
            $display("FAIL drop_idle: got ready %b left %h want 0 800", rdy_0, l_0);
        end
        en_f = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rdy_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_discard: got ready %b want 1", rdy_0);
        end
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (tk_0 === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (!seen || ur_0 !== 1'b1 || l_0 !== 12'h800) begin
            n_fail++;
            $display("FAIL drop_underrun: got tick %b underrun %b left %h want 1 1 800", seen, ur_0, l_0);
        end
        en_f = 1'b0;
    endtask

    task automatic test_aclr();
        logic ticked, full;
        ticked = 1'b0; full = 1'b0;
        do_reset();
        en_f = 1'b1;
        src_valid = 1'b1;
        src_left  = 12'h7FF;
        src_right = 12'h7FF;
        for (int c = 0; c < 200 && !full; c++) begin
            @(negedge clk);
            if (tk_0 === 1'b1) ticked = 1'b1;
            else if (ticked && rdy_0 === 1'b0) full = 1'b1;
        end
        n_checks++;
        if (!full || l_0 !== 12'h7FF || dut_0.state !== FULL) begin
            n_fail++;
            $display("FAIL aclr_setup: got full %b left %h want 1 7ff", full, l_0);
        end
        #2 aclr = 1'b1;
        #1;
        n_checks++;
        if ({l_0, r_0} !== {12'h800, 12'h800} || rdy_0 !== 1'b0 || dut_0.state !== IDLE) begin
            n_fail++;
            $display("FAIL aclr_async: got %h %h ready %b want 800 800 0", l_0, r_0, rdy_0);
        end
        n_checks++;
        if (tk_0 !== 1'b0 || ur_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL aclr_pulses: got tick %b underrun %b want 0 0", tk_0, ur_0);
        end
`ifdef AUDIO_SCHED_UNDERRUN_COUNT_EN
        n_checks++;
        if (uc_0 !== 16'd0) begin
            n_fail++;
            $display("FAIL aclr_count: got %0d want 0", uc_0);
        end
`endif
        src_valid = 1'b0;
        en_f = 1'b0;
        @(negedge clk);
        aclr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tick_fast();
        test_tick_default();
        test_ramp();
        test_underrun();
        test_bypass();
        test_enable_drop();
        test_aclr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
Sequences the stereo PCM path into the delta-sigma modulator at a fixed 44.1 kHz sample rate derived from the 50 MHz system clock.
- A fractional phase accumulator generates the sample tick.
- The block prefetches one stereo sample from an upstream source through a valid/ready handshake.
- Each tick presents the held sample on left_pcm/right_pcm to the DSM.
- Underruns are detected, flagged and handled deterministically.

Parameters:
AUDIO_BITS, 12, PCM width per channel (unsigned, offset-binary).
ACC_W, 24, phase accumulator width.
PHASE_INC, 14798, accumulator increment per clk (round(44100*2^24/50e6)).
MUTE_ON_UNDERRUN, 0, 1 = output MUTE_VALUE on underrun; 0 = hold last sample.

Ports:
clk  in  1  system clock (50 MHz)
aclr  in  1  asynchronous reset, active-high
enable  in  1  run request; 0 = idle, no fetch, no ticks
src_valid  in  1  upstream sample valid
src_ready  out  1  scheduler can accept a sample
src_left  in  AUDIO_BITS  upstream left sample
src_right  in  AUDIO_BITS  upstream right sample
left_pcm  out  AUDIO_BITS  registered left sample to DSM
right_pcm  out  AUDIO_BITS  registered right sample to DSM
sample_tick  out  1  one-clk pulse at the 44.1 kHz sample instant
underrun  out  1  one-clk pulse when a tick finds no sample

Behaviour:
Interface: reset aclr, asynchronous, active-high; clock clk.

Constants and reset:
- MUTE_VALUE = 1 << (AUDIO_BITS-1) (midscale).
- Reset values: acc=0, state=IDLE, src_ready=0, sample_tick=0, underrun=0, left_pcm=right_pcm=MUTE_VALUE, prefetch regs=MUTE_VALUE.

Tick generator:
- While enable=1: acc <= acc + PHASE_INC (mod 2^ACC_W).
- sample_tick is registered; it is 1 in the cycle after the add carries out of bit ACC_W-1.
- While enable=0: acc is cleared to 0 and no ticks occur.

Handshake:
- A transfer occurs in a cycle where src_valid & src_ready are both 1.
- src_ready is a registered state decode: 1 only in FETCH.
- The source may change data only after a transfer.

FSM:
- IDLE: src_ready=0. enable=1 -> FETCH.
- FETCH: src_ready=1.
  - Transfer without tick: latch into prefetch regs -> FULL.
  - Tick without transfer: underrun pulse; outputs hold (MUTE_ON_UNDERRUN=0) or load MUTE_VALUE (=1); stay FETCH.
  - Tick and transfer in the same cycle: the sample bypasses straight to left_pcm/right_pcm; no underrun; stay FETCH.
- FULL: src_ready=0. Tick: left_pcm/right_pcm <= prefetch; -> FETCH.

Enable and reset edge cases:
- enable=0 in any state -> IDLE next cycle. Any prefetched sample is discarded. Outputs hold their last value.
- A tick coinciding with enable falling is suppressed, because acc clears.
- aclr mid-operation returns every register to its reset value immediately.

Output timing and latency:
- Outputs change only in the cycle following a tick, so they are stable for >=1133 clks. The DSM samples them from its PLL clock domain without further synchronisation.
- Latency from transfer to output is until the next tick (0 clks in the bypass case).

Optional Feature:
Macro AUDIO_SCHED_UNDERRUN_COUNT_EN.
- Defined: adds output underrun_count [15:0].
  - Increments on each underrun pulse and saturates at 16'hFFFF.
  - Reset value 0; cleared when enable=0.
- Undefined: the port and counter are absent; underrun pulse only.

Decomposition:
- Shared audio package holds:
  - state enum {IDLE, FETCH, FULL};
  - AUDIO_BITS default;
  - SYS_CLK_HZ=50_000_000 and SAMPLE_HZ=44_100;
  - PHASE_INC default computation.
- One natural sub-module: audio_phase_tick, containing the accumulator plus the registered carry pulse with enable/clear. It is reusable for other sample rates.

Test Plan:
1. Override PHASE_INC=2^(ACC_W-2), enable=1 -> sample_tick pulses exactly every 4 clks; first pulse on clk 5 after enable.
2. Defaults, 10^6 clks -> exactly 882 sample_tick pulses (±1); no two ticks closer than 1133 clks.
3. Source always valid with ramp 0,1,2,... -> left_pcm/right_pcm step 0,1,2,... once per tick; underrun never asserts.
4. src_valid held 0 for 3 ticks, MUTE_ON_UNDERRUN=0 then 1 -> 3 underrun pulses; outputs hold 0x2A5 (case 0) or 0x800 (case 1).
5. src_valid asserted exactly on a tick cycle while in FETCH with data 0x123 -> left_pcm=0x123 next cycle; no underrun; src_ready stays 1.
6. aclr pulsed while in FULL holding 0x7FF -> outputs=0x800, src_ready=0, state IDLE asynchronously; with the macro defined, underrun_count=0.
